// File: rtl/mont_pre_scale_pkg.sv
// Shared definitions for the Montgomery-domain pre-scaler: iteration count helpers
// and the sequencing FSM encoding.
package mont_pre_scale_pkg;

  localparam int W_SIZE_DEF   = 16;
  localparam int L_STAGES_DEF = 2;

  function automatic int calc_k(input int w_size, input int l_stages);
    return w_size * l_stages;
  endfunction

  // Counter must be able to hold K itself (value left behind in DONE).
  function automatic int calc_cnt_w(input int k);
    return $clog2(k + 1);
  endfunction

  localparam int K     = calc_k(W_SIZE_DEF, L_STAGES_DEF);
  localparam int CNT_W = calc_cnt_w(K);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mont_pre_scale_dbl_step.sv
// Combinational modular doubling: y = (2x >= q) ? 2x - q : 2x, valid for x < q.
module mod_dbl_step #(
  parameter int DATA_SIZE = 32
) (
  input  logic [DATA_SIZE-1:0] x_i,
  input  logic [DATA_SIZE-1:0] q_i,
  output logic [DATA_SIZE-1:0] y_o
);

  logic [DATA_SIZE:0] t;
  logic               sub;

  assign t   = {x_i, 1'b0};
  assign sub = (t >= {1'b0, q_i});
  // When sub is set and x < q, 2x - q < q fits in DATA_SIZE bits, so the low-bit
  // difference is exact; when clear, t < q and its top bit is zero.
  assign y_o = sub ? (t[DATA_SIZE-1:0] - q_i) : t[DATA_SIZE-1:0];

endmodule

// File: rtl/mont_pre_scale.sv
// Bit-serial pre-scaler: out = a * 2^(W_SIZE*L_STAGES) mod q, one modular doubling per cycle.
//   state | meaning
//   IDLE  | ready for a coefficient, in_ready=1
//   RUN   | K doubling steps in progress
//   DONE  | result held on out_data until consumed
module mont_pre_scale
  import mont_pre_scale_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int W_SIZE    = W_SIZE_DEF,
  parameter int L_STAGES  = L_STAGES_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_SIZE-1:0] q,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int                M_K      = calc_k(W_SIZE, L_STAGES);
  localparam int                M_CNT_W  = calc_cnt_w(M_K);
  localparam logic [M_CNT_W-1:0] CNT_LAST = M_CNT_W'(M_K - 1);

  state_e               state_q, state_d;
  logic [M_CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_SIZE-1:0] x_q, x_d;
  logic [DATA_SIZE-1:0] q_r_q, q_r_d;
  logic [DATA_SIZE-1:0] step_y;

  mod_dbl_step #(.DATA_SIZE(DATA_SIZE)) u_step (
    .x_i (x_q),
    .q_i (q_r_q),
    .y_o (step_y)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    q_r_d     = q_r_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = ST_RUN;
          q_r_d   = q;
          cnt_d   = '0;
          // Inputs may be up to 2q-1; bring them below q before doubling.
          x_d     = (in_data >= q) ? (in_data - q) : in_data;
        end
      end
      ST_RUN: begin
        x_d   = step_y;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      q_r_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      q_r_q   <= q_r_d;
    end
  end

  assign out_data = x_q;

endmodule

// File: tb/tb_mont_pre_scale.sv
// Directed and randomized checks of mont_pre_scale at q=12289/K=12 and at q=3*2^30+1/K=32.
module tb_mont_pre_scale;

  localparam longint QS  = 12289;
  localparam int     KS  = 12;
  localparam longint QL  = 64'd3221225473;
  localparam int     KL  = 32;
  localparam longint QHL = 49152;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [15:0] s_q, s_in_data, s_out_data;
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [31:0] l_q, l_in_data, l_out_data;
  logic        l_in_valid, l_in_ready, l_out_valid, l_out_ready;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mont_pre_scale #(.DATA_SIZE(16), .W_SIZE(12), .L_STAGES(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .q(s_q), .in_data(s_in_data), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .out_data(s_out_data), .out_valid(s_out_valid),
    .out_ready(s_out_ready)
  );

  mont_pre_scale #(.DATA_SIZE(32), .W_SIZE(16), .L_STAGES(2)) dut_l (
    .clk(clk), .rst_n(rst_n), .q(l_q), .in_data(l_in_data), .in_valid(l_in_valid),
    .in_ready(l_in_ready), .out_data(l_out_data), .out_valid(l_out_valid),
    .out_ready(l_out_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint model_s(input longint a);
    return ((a % QS) * 4096) % QS;
  endfunction

  function automatic longint model_l(input longint a);
    longint r;
    r = ((a % QL) * 65536) % QL;
    return (r * 65536) % QL;
  endfunction

  // One word-level K-RED stage for q = qH*2^16 + 1: result == qH*c (mod q).
  function automatic longint kred(input longint c);
    longint c1, c0;
    c1 = c >>> 16;
    c0 = c & 64'hFFFF;
    return QHL * c0 - c1;
  endfunction

  task automatic run_s(input longint a, input longint exp, input string tag);
    int lat;
    chk({tag, "_in_ready"}, s_in_ready, 1);
    s_in_data  = a[15:0];
    s_in_valid = 1'b1;
    tick();
    s_in_valid = 1'b0;
    lat = 0;
    while (!s_out_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, KS);
    chk({tag, "_data"}, s_out_data, exp);
    tick();
    chk({tag, "_valid_drop"}, s_out_valid, 0);
    chk({tag, "_ready_back"}, s_in_ready, 1);
  endtask

  task automatic run_l(input longint a, output longint res);
    int lat;
    l_in_data  = a[31:0];
    l_in_valid = 1'b1;
    tick();
    l_in_valid = 1'b0;
    lat = 0;
    while (!l_out_valid && lat < 200) begin
      tick();
      lat++;
    end
    chk("l_latency", lat, KL);
    res = longint'(l_out_data);
    tick();
  endtask

  initial begin
    longint a, res, r, m;
    longint arr[50];
    int idx, nres, cyc, last_cyc;
    logic acc, hs;

    s_q = 16'(QS); s_in_data = '0; s_in_valid = 0; s_out_ready = 1;
    l_q = 32'(QL); l_in_data = '0; l_in_valid = 0; l_out_ready = 1;

    #12;
    chk("rst_in_ready",  s_in_ready, 1);
    chk("rst_out_valid", s_out_valid, 0);
    chk("rst_out_data",  s_out_data, 0);
    chk("rst_l_in_ready", l_in_ready, 1);
    #10 rst_n = 1'b1;

    // basic and edge values
    run_s(1, 4096, "a1");
    run_s(4, 4095, "a4");
    run_s(3, 12288, "a3");
    run_s(QS + 5, 8191, "aq5");
    run_s(0, 0, "a0");
    run_s(QS - 1, 8193, "aqm1");

    // backpressure
    s_out_ready = 1'b0;
    s_in_data = 16'd1; s_in_valid = 1'b1;
    tick();
    s_in_data = 16'd4;
    idx = 0;
    while (!s_out_valid && idx < 100) begin tick(); idx++; end
    chk("bp_latency", idx, KS);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_valid", s_out_valid, 1);
      chk("bp_data", s_out_data, 4096);
      chk("bp_in_ready", s_in_ready, 0);
    end
    s_in_valid = 1'b0;
    s_out_ready = 1'b1;
    tick();
    chk("bp_release_valid", s_out_valid, 0);
    chk("bp_release_ready", s_in_ready, 1);

    // reset mid-RUN
    s_in_data = 16'd1; s_in_valid = 1'b1;
    tick();
    s_in_valid = 1'b0;
    repeat (5) tick();
    chk("mid_in_ready_low", s_in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", s_in_ready, 1);
    chk("mid_rst_out_valid", s_out_valid, 0);
    chk("mid_rst_out_data", s_out_data, 0);
    #2 rst_n = 1'b1;
    run_s(4, 4095, "post_rst_a4");

    // round trip through two K-RED stages
    for (int i = 0; i < 1000; i++) begin
      a = longint'($urandom_range(32'(QL - 1), 0));
      run_l(a, res);
      chk("l_model", res, model_l(a));
      r = kred(kred(res));
      m = r % QL;
      if (m < 0) m += QL;
      chk("l_roundtrip", m, a);
    end

    // back-to-back stream
    for (int i = 0; i < 50; i++) arr[i] = longint'($urandom_range(32'(2 * QS - 1), 0));
    idx = 0; nres = 0; cyc = 0; last_cyc = 0;
    s_in_data = arr[0][15:0];
    s_in_valid = 1'b1;
    s_out_ready = 1'b1;
    while (nres < 50 && cyc < 2000) begin
      acc = s_in_ready && s_in_valid;
      hs  = s_out_valid && s_out_ready;
      if (hs) begin
        chk("stream_data", s_out_data, model_s(arr[nres]));
        if (nres > 0) chk("stream_period", cyc - last_cyc, KS + 2);
        last_cyc = cyc;
        nres++;
      end
      tick();
      cyc++;
      if (acc) begin
        idx++;
        if (idx < 50) s_in_data = arr[idx][15:0];
        else s_in_valid = 1'b0;
      end
    end
    chk("stream_count", nres, 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
